// File: rtl/sr_mdu_pkg.sv
// rtl/sr_mdu_pkg.sv - shared encodings for the sequential multiply/divide unit
package sr_mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MUL   = 2'b00,
      MDU_MULHU = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_REMU  = 2'b11
   } mduOp_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mduState_t;

endpackage

// File: rtl/sr_mdu.sv
// rtl/sr_mdu.sv - iterative unsigned multiply (shift-add) and divide (restoring)
// sharing one shift register pair {hi,lo} and one adder/subtractor.
module sr_mdu
   import sr_mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(ITER) + 1;

   mduState_t        state, stateNext;
   mduOp_t           opReg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi, lo, bReg;
   logic [WIDTH-1:0] hiNext, loNext, resultNext;
   logic [WIDTH+1:0] addX, addY, addSum;
   logic             isDiv, hiWord, lastIter;

   assign isDiv    = (opReg == MDU_DIVU) || (opReg == MDU_REMU);
   assign hiWord   = (opReg == MDU_MULHU) || (opReg == MDU_REMU);
   assign lastIter = (cnt == CW'(ITER - 1));

   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   // Multiply: hi:lo is the product accumulator, lo's LSB is the current multiplier bit.
   always_comb begin
      addX       = isDiv ? {1'b0, hi, lo[WIDTH-1]} : {2'b00, hi};
      addY       = {2'b00, bReg};
      addSum     = isDiv ? (addX - addY) : (addX + addY);
      hiNext     = hi;
      loNext     = lo;
      if (isDiv) begin
         if (addSum[WIDTH+1]) begin
            hiNext = addX[WIDTH-1:0];
            loNext = {lo[WIDTH-2:0], 1'b0};
         end else begin
            hiNext = addSum[WIDTH-1:0];
            loNext = {lo[WIDTH-2:0], 1'b1};
         end
      end else if (lo[0]) begin
         {hiNext, loNext} = {addSum[WIDTH:0], lo[WIDTH-1:1]};
      end else begin
         {hiNext, loNext} = {1'b0, hi, lo[WIDTH-1:1]};
      end
      resultNext = hiWord ? hiNext : loNext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start)    stateNext = RUN;
         RUN:     if (lastIter) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opReg  <= MDU_MUL;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         bReg   <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               opReg <= mduOp_t'(op);
               bReg  <= srcB;
               lo    <= srcA;
               hi    <= '0;
               cnt   <= '0;
            end
         end else begin
            hi  <= hiNext;
            lo  <= loNext;
            cnt <= cnt + CW'(1);
            if (lastIter) begin
               result <= resultNext;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sr_mdu.sv
// tb/tb_sr_mdu.sv - self-checking bench for sr_mdu
module tb_sr_mdu;
   import sr_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srcA, srcB;
   logic [31:0] result;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   sr_mdu #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .srcA(srcA), .srcB(srcB), .result(result), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy && done) begin
         errors++;
         $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
   end

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic waitDone(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; srcA = a; srcB = b;
      @(negedge clk);
      start = 1'b0;
      waitDone(n);
      check({name, "_busyCycles"}, 64'(n), 64'd32);
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_result"}, 64'(result), 64'(exp));
      @(negedge clk);
      check({name, "_donePulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n, dones;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      vecs[0] = '{MDU_MUL,   32'd7,          32'd6,          32'h0000_002A};
      vecs[1] = '{MDU_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
      vecs[2] = '{MDU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
      vecs[3] = '{MDU_DIVU,  32'd100,        32'd7,          32'h0000_000E};
      vecs[4] = '{MDU_REMU,  32'd100,        32'd7,          32'h0000_0002};
      vecs[5] = '{MDU_DIVU,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
      vecs[6] = '{MDU_REMU,  32'h0000_1234,  32'd0,          32'h0000_1234};

      rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case (i % 4)
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         runOp(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i));
      end

      // start during RUN must be ignored
      @(negedge clk);
      start = 1'b1; op = MDU_MUL; srcA = 32'd3; srcB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = MDU_DIVU; srcA = 32'd9; srcB = 32'd3;
      @(negedge clk);
      start = 1'b0;
      waitDone(n);
      check("ignore_busyRemaining", 64'(n), 64'd27);
      check("ignore_done", 64'(done), 64'd1);
      check("ignore_result", 64'(result), 64'h0F);
      @(negedge clk);
      check("ignore_noRestart", 64'(busy), 64'd0);

      // reset in RUN cycle 10 aborts without a done pulse
      start = 1'b1; op = MDU_MUL; srcA = 32'd5; srcB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_noDone", 64'(dones), 64'd0);
      runOp(MDU_MUL, 32'd2, 32'd2, 32'd4, "afterReset");

      // start held through done: back-to-back with no idle cycle
      @(negedge clk);
      start = 1'b1; op = MDU_MUL; srcA = 32'd4; srcB = 32'd4;
      @(negedge clk);
      waitDone(n);
      check("b2b_first_busyCycles", 64'(n), 64'd32);
      check("b2b_first_done", 64'(done), 64'd1);
      check("b2b_first_result", 64'(result), 64'h10);
      op = MDU_DIVU; srcA = 32'd100; srcB = 32'd7;
      @(negedge clk);
      check("b2b_busyRises", 64'(busy), 64'd1);
      check("b2b_doneDrops", 64'(done), 64'd0);
      start = 1'b0;
      waitDone(n);
      check("b2b_second_busyCycles", 64'(n), 64'd32);
      check("b2b_second_done", 64'(done), 64'd1);
      check("b2b_second_result", 64'(result), 64'h0E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
